// File: rtl/audio_pkg.sv
// Shared definitions for the Pocket audio path: default frame geometry,
// receiver state encoding and the 48 kHz frame period in clk_74a cycles.
package audio_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int SLOT_WIDTH_DEF   = 32;
  localparam int SYNC_STAGES_DEF  = 2;

  // 74.25 MHz / 48 kHz = 1546.875, rounded to the nearest whole cycle
  localparam int CYCLE_48KHZ = 1547;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input plus a registered
// rising-edge detector. o_level is delayed one cycle so it lines up with o_rise.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_74a,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // Synchronise the input and register the 0->1 transition of the synced value
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S receiver for the audio_adc input. Deframes standard I2S (MSB one sclk
// after the lrck edge, lrck low = left) and publishes one left/right pair per frame.
// Optional feature macro: I2S_RX_ERR_COUNT_EN enables the saturating err_count.
//
// state | meaning
// HUNT  | waiting for the first lrck change to find a slot boundary
// LEFT  | receiving a left slot
// RIGHT | receiving a right slot
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic                    i2s_sclk,
  input  logic                    i2s_lrck,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_err,
  output logic                    locked,
  output logic [15:0]             err_count
);

  localparam int CW = $clog2(SLOT_WIDTH + 1);

  logic w_sclk_rise, w_lrck, w_sdata;
  logic w_unused_sclk_level, w_unused_lrck_rise, w_unused_sdata_rise;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_74a(clk_74a), .reset_n(reset_n), .i_async(i2s_sclk),
    .o_level(w_unused_sclk_level), .o_rise(w_sclk_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk_74a(clk_74a), .reset_n(reset_n), .i_async(i2s_lrck),
    .o_level(w_lrck), .o_rise(w_unused_lrck_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk_74a(clk_74a), .reset_n(reset_n), .i_async(i2s_sdata),
    .o_level(w_sdata), .o_rise(w_unused_sdata_rise));

  rx_state_t               r_state, w_next_state;
  logic                    r_primed;
  logic                    r_lrck_prev;
  logic [CW-1:0]           r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_sh_l, r_sh_r, r_left_hold;
  logic                    r_left_ok;
  logic [SAMPLE_WIDTH-1:0] r_sample_left, r_sample_right;
  logic                    r_sample_valid, r_frame_err, r_locked;

  logic w_change, w_slot_ok, w_publish, w_err, w_latch_left, w_clr_left_ok;

  // The first rise after reset only records lrck, so a reset inside a slot
  // never looks like a slot boundary.
  assign w_change  = w_sclk_rise & r_primed & (w_lrck != r_lrck_prev);
  assign w_slot_ok = (r_cnt == CW'(SLOT_WIDTH - 1));

  // State register
  always_ff @(posedge clk_74a) begin
    if (!reset_n) r_state <= ST_HUNT;
    else          r_state <= w_next_state;
  end

  // Next-state and slot-boundary decisions
  always_comb begin
    w_next_state  = r_state;
    w_publish     = 1'b0;
    w_err         = 1'b0;
    w_latch_left  = 1'b0;
    w_clr_left_ok = 1'b0;
    if (w_change) begin
      case (r_state)
        ST_HUNT:  w_next_state = w_lrck ? ST_RIGHT : ST_LEFT;
        ST_LEFT: begin
          if (w_slot_ok) w_latch_left = 1'b1;
          else           w_err        = 1'b1;
          w_next_state = ST_RIGHT;
        end
        ST_RIGHT: begin
          if (!w_slot_ok)     w_err     = 1'b1;
          else if (r_left_ok) w_publish = 1'b1;
          w_clr_left_ok = 1'b1;
          w_next_state  = ST_LEFT;
        end
        default: w_next_state = ST_HUNT;
      endcase
    end
    if (w_err) w_clr_left_ok = 1'b1;
  end

  // Slot counter, per-channel shifters, left hold and publish registers
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_primed       <= 1'b0;
      r_lrck_prev    <= 1'b0;
      r_cnt          <= '0;
      r_sh_l         <= '0;
      r_sh_r         <= '0;
      r_left_hold    <= '0;
      r_left_ok      <= 1'b0;
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_sample_valid <= w_publish;
      r_frame_err    <= w_err;
      if (w_sclk_rise) begin
        r_primed    <= 1'b1;
        r_lrck_prev <= w_lrck;
        if (w_change) begin
          r_cnt <= '0;
        end else begin
          if (r_cnt != CW'(SLOT_WIDTH)) r_cnt <= r_cnt + 1'b1;
          if (int'(r_cnt) < SAMPLE_WIDTH) begin
            if (w_lrck) r_sh_r <= {r_sh_r[SAMPLE_WIDTH-2:0], w_sdata};
            else        r_sh_l <= {r_sh_l[SAMPLE_WIDTH-2:0], w_sdata};
          end
        end
      end
      if (w_latch_left) begin
        r_left_hold <= r_sh_l;
        r_left_ok   <= 1'b1;
      end else if (w_clr_left_ok) begin
        r_left_ok   <= 1'b0;
      end
      if (w_publish) begin
        r_sample_left  <= r_left_hold;
        r_sample_right <= r_sh_r;
        r_locked       <= 1'b1;
      end else if (w_err) begin
        r_locked       <= 1'b0;
      end
    end
  end

  assign sample_left  = r_sample_left;
  assign sample_right = r_sample_right;
  assign sample_valid = r_sample_valid;
  assign frame_err    = r_frame_err;
  assign locked       = r_locked;

`ifdef I2S_RX_ERR_COUNT_EN
  logic [15:0] r_err_count;

  // Saturating framing-error counter, cleared only by reset
  always_ff @(posedge clk_74a) begin
    if (!reset_n)                            r_err_count <= 16'h0000;
    else if (w_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'h0001;
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'h0000;
`endif

endmodule
